// File: rtl/fir_mac_pkg.sv
// Shared types and arithmetic helpers for the FIR MAC sequencer.
// FIR_ROUND_SAT_EN selects round-half-up plus saturation in fir_scale; undefined gives a wrapping truncation.
package fir_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACC,
        DRAIN,
        OUT
    } fir_state_t;

    localparam int unsigned SCALE_W = 128;
    localparam logic signed [SCALE_W-1:0] SCALE_ONE = 1;

    function automatic int unsigned fir_acc_width(input int unsigned dw, input int unsigned taps);
        return 2 * dw + $clog2(taps);
    endfunction

    // Result is sign-correct in DW bits; callers keep the low DW bits.
    function automatic logic signed [SCALE_W-1:0] fir_scale(
        input logic signed [SCALE_W-1:0] acc,
        input int unsigned               frac,
        input int unsigned               dw
    );
        logic signed [SCALE_W-1:0] r;
`ifdef FIR_ROUND_SAT_EN
        logic signed [SCALE_W-1:0] hi;
        logic signed [SCALE_W-1:0] lo;
        hi = (SCALE_ONE <<< (dw - 1)) - SCALE_ONE;
        lo = -(SCALE_ONE <<< (dw - 1));
        r  = (acc + (SCALE_ONE <<< (frac - 1))) >>> frac;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
`else
        r = acc >>> frac;
        r = (r <<< (SCALE_W - dw)) >>> (SCALE_W - dw);
`endif
        return r;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample delay line: write at wr_ptr, read at (wr_ptr - tap) mod TAPS.
module fir_delay_line #(
    parameter int unsigned TAPS = 32,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          adv_i,
    input  logic [AW-1:0] tap_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] buf_q [TAPS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_idx;

    // TAPS is a power of two, so AW-bit subtraction gives the modulo wrap.
    assign rd_idx  = wr_ptr_q - tap_i;
    assign rdata_o = buf_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            if (we_i) begin
                buf_q[wr_ptr_q] <= wdata_i;
            end
            if (adv_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// TAPS-tap FIR filter built by sequencing an external pipelined MAC.
// Build option: FIR_ROUND_SAT_EN enables rounding and saturation of the scaled output.
module fir_mac_sequencer
    import fir_mac_pkg::*;
#(
    parameter int unsigned TAPS        = 32,
    parameter int unsigned DW          = 16,
    parameter int unsigned COEF_FRAC   = 15,
    parameter int unsigned MAC_LATENCY = 2,
    parameter int unsigned PSIZE       = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DW-1:0]            coef_data,
    output logic                     busy,
    output logic                     mac_ce,
    output logic                     mac_reload,
    output logic [DW-1:0]            mac_a,
    output logic [DW-1:0]            mac_b,
    input  logic [PSIZE-1:0]         mac_p
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned ACC_W = fir_acc_width(DW, TAPS);
    localparam int unsigned DCW   = $clog2(MAC_LATENCY + 1);
    localparam logic [AW-1:0]  TAP_LAST   = AW'(TAPS - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MAC_LATENCY - 1);

    fir_state_t state_q, state_d;
    logic [AW-1:0]  tap_q, tap_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [DW-1:0]  out_q, out_d;
    logic [DW-1:0]  coef_q [TAPS];
    logic [DW-1:0]  dl_rdata;
    logic           dl_we;
    logic           dl_adv;
    logic signed [SCALE_W-1:0] acc_ext;
    logic signed [SCALE_W-1:0] scaled;
    logic           mac_p_unused;
    logic           scaled_unused;

    fir_delay_line #(
        .TAPS (TAPS),
        .DW   (DW),
        .AW   (AW)
    ) u_delay (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (dl_we),
        .wdata_i (in_data),
        .adv_i   (dl_adv),
        .tap_i   (tap_q),
        .rdata_o (dl_rdata)
    );

    assign acc_ext       = {{(SCALE_W - ACC_W){mac_p[ACC_W-1]}}, mac_p[ACC_W-1:0]};
    assign scaled        = fir_scale(acc_ext, COEF_FRAC, DW);
    assign mac_p_unused  = ^mac_p[PSIZE-1:ACC_W];
    assign scaled_unused = ^scaled[SCALE_W-1:DW];
    assign out_data      = out_q;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        dcnt_d     = dcnt_q;
        out_d      = out_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        mac_ce     = 1'b0;
        mac_reload = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        dl_we      = 1'b0;
        dl_adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    dl_we   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mac_ce     = 1'b1;
                mac_reload = 1'b1;
                tap_d      = '0;
                state_d    = ACC;
            end
            ACC: begin
                mac_ce = 1'b1;
                mac_a  = dl_rdata;
                mac_b  = coef_q[tap_q];
                tap_d  = tap_q + 1'b1;
                if (tap_q == TAP_LAST) begin
                    dl_adv  = 1'b1;
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mac_ce = 1'b1;
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DRAIN_LAST) begin
                    out_d   = scaled[DW-1:0];
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tap_q   <= '0;
            dcnt_q  <= '0;
            out_q   <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            dcnt_q  <= dcnt_d;
            out_q   <= out_d;
            // Writes land in IDLE only, so a write beside an accepted sample still precedes ACC.
            if (coef_we && (state_q == IDLE)) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Drives the 16-bit multiply-accumulator IP (`multiply_accumulator_16bit`) as its initiator, turning it into a TAPS-tap FIR filter for audio samples. Each accepted sample is written into a circular delay line. The block then issues one reload cycle and TAPS accumulate cycles to the MAC, waits out the MAC pipeline, and captures the accumulator. The captured sum is scaled and presented on a valid/ready output. It sits between the codec RX sample stream and downstream audio processing.

## Interface
Parameters:
- TAPS, 32, number of filter taps; power of two, 2..256
- DW, 16, sample and coefficient width (signed)
- COEF_FRAC, 15, coefficient fractional bits (Q1.15); output = acc >>> COEF_FRAC
- MAC_LATENCY, 2, cycles from presenting a/b to mac_p reflecting it (MAC built with INREG off, PIPEREG on)
- PSIZE, 96, MAC output width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  high only in IDLE
- in_data  in  DW  signed sample
- out_valid  out  1  filtered sample available
- out_ready  in  1  downstream accepts
- out_data  out  DW  signed filtered sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  tap index i (coefficient h[i])
- coef_data  in  DW  signed coefficient
- busy  out  1  state != IDLE
- mac_ce  out  1  MAC clock enable
- mac_reload  out  1  MAC accumulator reload (init value 0)
- mac_a  out  DW  sample operand
- mac_b  out  DW  coefficient operand
- mac_p  in  PSIZE  MAC accumulator output

## Operation
- States: IDLE, LOAD, ACC, DRAIN, OUT.
- IDLE:
  - in_ready=1, mac_ce=0.
  - On in_valid: write in_data to buf[wr_ptr] and go to LOAD. wr_ptr advances after ACC completes.
- LOAD: one cycle; mac_ce=1, mac_reload=1, mac_a=mac_b=0.
- ACC: TAPS cycles with tap counter i=0..TAPS-1.
  - mac_ce=1, mac_a=buf[(wr_ptr-i) mod TAPS], mac_b=h[i].
  - On i=TAPS-1: wr_ptr<=wr_ptr+1 (wraps at TAPS).
- DRAIN: MAC_LATENCY cycles; mac_ce=1, mac_a=mac_b=0.
  - On the last DRAIN cycle, register mac_p[ACC_W-1:0], scale it, and go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - out_valid&out_ready -> IDLE.
  - mac_ce=0.
- Arithmetic:
  - ACC_W = 2*DW + log2(TAPS).
  - Scaling is an arithmetic shift right by COEF_FRAC, then rounding/saturation per Configuration.
- Coefficients:
  - Written only when busy=0.
  - coef_we while busy is dropped silently.
  - A write takes effect for the next accepted sample.
- Simultaneous in_valid and coef_we in IDLE: both are taken; the new coefficient applies to that sample.
- Reset:
  - Delay line, coefficients and wr_ptr cleared to 0.
  - State -> IDLE.
  - Reset mid-computation abandons it; no output is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, mac_ce=0, mac_reload=0, mac_a=0, mac_b=0.
- Latency:
  - Accept cycle c0; LOAD c1; ACC c2..c(TAPS+1); DRAIN through c(TAPS+1+MAC_LATENCY).
  - out_valid rises in cycle c0+TAPS+MAC_LATENCY+2 (36 at defaults).
- Throughput: one sample per TAPS+MAC_LATENCY+3 cycles when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data is stable and in_ready=0.

## Configuration
- FIR_ROUND_SAT_EN defined:
  - Add 2^(COEF_FRAC-1) before the shift.
  - Saturate the result to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: truncating shift; out_data = low DW bits of the shifted value (wraps).

## Structure
- fir_mac_pkg holds:
  - state enum
  - ACC_W derivation function
  - scale/round/saturate function, selected by the macro
- Sub-module fir_delay_line holds:
  - TAPS x DW register array with combinational read
  - wr_ptr, with write and advance controls
- Coefficient register file and FSM live in the top level.

## Test plan
- h[0]=0x4000, other taps 0; in_data=0x2000 -> out_data=0x1000, out_valid exactly 36 cycles after the accept.
- h[1]=0x4000, other taps 0; inputs 0x1000 then 0x2000 -> outputs 0x0000 then 0x0800 (checks delay-line order and wrap).
- h[0]=0x8000 (-1), input 0x1234 -> 0xEDCC.
- All h=0x7FFF; 32 inputs of 0x7FFF; 32nd output:
  - with FIR_ROUND_SAT_EN: 0x7FFF
  - without: 0xFFC0
- h[0]=0x4000, input 0x0001 -> 0x0001 with macro, 0x0000 without.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: out_data stable, in_ready=0.
  - Pulse rst_n low during ACC: all outputs at reset values, no out_valid, then the next sample sees a zeroed delay line.
